// File: rtl/sccb_cmd_arbiter.sv
// rtl/sccb_cmd_arbiter.sv - two-source arbiter, launcher and timeout guard for the SCCB master
module sccb_cmd_arbiter #(
  parameter logic [7:0]  DEV_ID         = 8'h42,
  parameter int          GAP_CYCLES     = 125,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic       rxclk,
  input  logic       rxreset,
  input  logic       init_req,
  input  logic       init_wr,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_wdata,
  output logic       init_gnt,
  output logic       init_done,
  output logic       init_err,
  input  logic       pc_req,
  input  logic       pc_wr,
  input  logic [7:0] pc_addr,
  input  logic [7:0] pc_wdata,
  output logic       pc_gnt,
  output logic       pc_done,
  output logic       pc_err,
  output logic [7:0] pc_rdata,
  output logic       m_start,
  output logic       m_abort,
  output logic       m_wr,
  output logic [7:0] m_id,
  output logic [7:0] m_addr,
  output logic [7:0] m_wdata,
  input  logic       m_done,
  input  logic       m_nack,
  input  logic [7:0] m_rdata,
  output logic       busy,
  output logic       owner
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  localparam logic [15:0] TO_LAST  = TIMEOUT_CYCLES - 16'd1;
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic        sel_pc;
  logic        gnt_i_d, gnt_p_d, start_d, abort_d, done_d, err_d, rd_d;

  assign m_id = DEV_ID;
  assign busy = (state != S_IDLE);

  // Next-state and pulse decode; both-requesting goes to whoever is not the last owner
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    gnt_i_d = 1'b0;
    gnt_p_d = 1'b0;
    start_d = 1'b0;
    abort_d = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rd_d    = 1'b0;
    sel_pc  = pc_req & (~init_req | ~owner);
    case (state)
      S_IDLE: begin
        if (init_req | pc_req) begin
          state_d = S_LAUNCH;
          gnt_p_d = sel_pc;
          gnt_i_d = ~sel_pc;
        end
      end
      S_LAUNCH: begin
        start_d = 1'b1;
        cnt_d   = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // m_done has priority over a timeout landing on the same edge
        if (m_done) begin
          done_d  = 1'b1;
          err_d   = m_nack;
          rd_d    = ~m_wr;
          cnt_d   = 16'd0;
          state_d = S_GAP;
        end else if (cnt == TO_LAST) begin
          abort_d = 1'b1;
          done_d  = 1'b1;
          err_d   = 1'b1;
          cnt_d   = 16'd0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) state_d = S_IDLE;
        else                 cnt_d   = cnt + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, registered pulses, command latch and per-requester status
  always_ff @(posedge rxclk) begin
    if (!rxreset) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      init_gnt  <= 1'b0;
      pc_gnt    <= 1'b0;
      m_start   <= 1'b0;
      m_abort   <= 1'b0;
      init_done <= 1'b0;
      pc_done   <= 1'b0;
      init_err  <= 1'b0;
      pc_err    <= 1'b0;
      pc_rdata  <= 8'h00;
      m_wr      <= 1'b0;
      m_addr    <= 8'h00;
      m_wdata   <= 8'h00;
      owner     <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      init_gnt  <= gnt_i_d;
      pc_gnt    <= gnt_p_d;
      m_start   <= start_d;
      m_abort   <= abort_d;
      init_done <= done_d & ~owner;
      pc_done   <= done_d & owner;
      if (done_d & ~owner)        init_err <= err_d;
      if (done_d & owner)         pc_err   <= err_d;
      if (done_d & rd_d & owner)  pc_rdata <= m_rdata;
      if (state == S_IDLE && (init_req | pc_req)) begin
        owner   <= sel_pc;
        m_wr    <= sel_pc ? pc_wr    : init_wr;
        m_addr  <= sel_pc ? pc_addr  : init_addr;
        m_wdata <= sel_pc ? pc_wdata : init_wdata;
      end
    end
  end

endmodule

// File: tb/tb_sccb_cmd_arbiter.sv
// tb/tb_sccb_cmd_arbiter.sv - directed self-checking bench for sccb_cmd_arbiter
module tb_sccb_cmd_arbiter;

  localparam int          GAP = 5;
  localparam logic [15:0] TO  = 16'd40;

  logic       rxclk = 1'b0;
  logic       rxreset;
  logic       init_req, init_wr;
  logic [7:0] init_addr, init_wdata;
  logic       init_gnt, init_done, init_err;
  logic       pc_req, pc_wr;
  logic [7:0] pc_addr, pc_wdata;
  logic       pc_gnt, pc_done, pc_err;
  logic [7:0] pc_rdata;
  logic       m_start, m_abort, m_wr;
  logic [7:0] m_id, m_addr, m_wdata;
  logic       m_done, m_nack;
  logic [7:0] m_rdata;
  logic       busy, owner;

  int total = 0;
  int bad   = 0;

  sccb_cmd_arbiter #(.DEV_ID(8'h42), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .rxclk(rxclk), .rxreset(rxreset),
    .init_req(init_req), .init_wr(init_wr), .init_addr(init_addr), .init_wdata(init_wdata),
    .init_gnt(init_gnt), .init_done(init_done), .init_err(init_err),
    .pc_req(pc_req), .pc_wr(pc_wr), .pc_addr(pc_addr), .pc_wdata(pc_wdata),
    .pc_gnt(pc_gnt), .pc_done(pc_done), .pc_err(pc_err), .pc_rdata(pc_rdata),
    .m_start(m_start), .m_abort(m_abort), .m_wr(m_wr), .m_id(m_id),
    .m_addr(m_addr), .m_wdata(m_wdata),
    .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata),
    .busy(busy), .owner(owner)
  );

  always #40 rxclk = ~rxclk;

  task automatic tick();
    @(posedge rxclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 400) begin
      tick();
      k++;
    end
    chk(tag, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    int  k;
    logic seen;
    logic exp_pc;

    rxreset = 1'b0;
    init_req = 0; init_wr = 0; init_addr = 0; init_wdata = 0;
    pc_req = 0; pc_wr = 0; pc_addr = 0; pc_wdata = 0;
    m_done = 0; m_nack = 0; m_rdata = 0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 1);
    chk("rst_rdata", pc_rdata, 8'h00);
    chk("rst_mwr", m_wr, 0);
    chk("rst_maddr", m_addr, 8'h00);
    chk("rst_errs", {init_err, pc_err}, 0);
    chk("rst_pulses", {init_gnt, pc_gnt, m_start, m_abort, init_done, pc_done}, 0);
    rxreset = 1'b1;
    tick();

    // pc write
    pc_req = 1; pc_wr = 1; pc_addr = 8'h13; pc_wdata = 8'hCC;
    tick();
    chk("wr_pc_gnt", pc_gnt, 1);
    chk("wr_init_gnt", init_gnt, 0);
    chk("wr_busy", busy, 1);
    pc_req = 0;
    tick();
    chk("wr_start", m_start, 1);
    chk("wr_cmd", {7'd0, m_wr, m_addr}, {7'd0, 1'b1, 8'h13});
    chk("wr_wdata", m_wdata, 8'hCC);
    chk("wr_id", m_id, 8'h42);
    m_done = 1; m_nack = 0;
    tick();
    m_done = 0;
    chk("wr_done", {pc_done, pc_err, m_abort, init_done}, 4'b1000);
    for (int i = 0; i < GAP - 1; i++) tick();
    chk("gap_still_busy", busy, 1);
    tick();
    chk("gap_idle", busy, 0);

    // pc read
    pc_req = 1; pc_wr = 0; pc_addr = 8'h13;
    tick();
    chk("rd_gnt", pc_gnt, 1);
    pc_req = 0;
    tick();
    chk("rd_start", {m_start, m_wr}, 2'b10);
    tick();
    m_done = 1; m_rdata = 8'h8F;
    tick();
    m_done = 0; m_rdata = 8'h00;
    chk("rd_done", {pc_done, pc_err}, 2'b10);
    chk("rd_data", pc_rdata, 8'h8F);
    wait_idle("rd_idle");

    // init read with nack; pc request raised during the gap
    init_req = 1; init_wr = 0; init_addr = 8'h0A;
    tick();
    chk("nk_gnt", {init_gnt, pc_gnt, owner}, 3'b100);
    init_req = 0;
    tick();
    chk("nk_start", m_start, 1);
    m_done = 1; m_nack = 1; m_rdata = 8'h55;
    tick();
    m_done = 0; m_nack = 0;
    chk("nk_done", {init_done, init_err, pc_done}, 3'b110);
    chk("nk_rdata_kept", pc_rdata, 8'h8F);
    pc_req = 1; pc_wr = 0; pc_addr = 8'h20;
    seen = 0;
    for (int i = 0; i < GAP; i++) begin
      tick();
      if (pc_gnt) seen = 1;
    end
    chk("gap_no_gnt", seen, 0);
    tick();
    chk("gap_gnt_after", pc_gnt, 1);

    // timeout on that pc read
    pc_req = 0;
    tick();
    chk("to_start", m_start, 1);
    seen = 0;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      if (m_abort || pc_done) seen = 1;
    end
    chk("to_early", seen, 0);
    tick();
    chk("to_fire", {m_abort, pc_done, pc_err}, 3'b111);
    chk("to_rdata", pc_rdata, 8'h8F);
    tick();
    chk("to_abort_1cyc", m_abort, 0);
    chk("to_err_held", pc_err, 1);
    wait_idle("to_idle");

    // m_done coincident with timeout edge
    init_req = 1; init_wr = 1; init_addr = 8'h3C; init_wdata = 8'h07;
    tick();
    chk("co_gnt", init_gnt, 1);
    init_req = 0;
    tick();
    chk("co_start", m_start, 1);
    for (int i = 0; i < TO - 1; i++) tick();
    m_done = 1; m_nack = 0;
    tick();
    m_done = 0;
    chk("co_done", {init_done, init_err, m_abort}, 3'b100);
    wait_idle("co_idle");

    // contention: owner is init, so pc wins first, then alternation
    init_req = 1; init_wr = 1; init_addr = 8'h01; init_wdata = 8'h11;
    pc_req = 1; pc_wr = 1; pc_addr = 8'h02; pc_wdata = 8'h22;
    exp_pc = 1;
    for (int t = 0; t < 4; t++) begin
      k = 0;
      do begin
        tick();
        k++;
      end while (!(init_gnt || pc_gnt) && k < 50);
      chk("ct_gnt", {init_gnt, pc_gnt}, {~exp_pc, exp_pc});
      if (t > 0) chk("ct_spacing", 16'(k), 16'(GAP + 1));
      tick();
      chk("ct_addr", m_addr, exp_pc ? 8'h02 : 8'h01);
      m_done = 1;
      tick();
      m_done = 0;
      chk("ct_done", {init_done, pc_done}, {~exp_pc, exp_pc});
      exp_pc = ~exp_pc;
    end
    init_req = 0; pc_req = 0;
    wait_idle("ct_idle");

    // reset mid-wait
    pc_req = 1; pc_wr = 1; pc_addr = 8'h44; pc_wdata = 8'h99;
    tick();
    pc_req = 0;
    tick(); tick(); tick();
    rxreset = 0;
    tick();
    rxreset = 1;
    chk("mr_state", {busy, owner, init_done, pc_done, m_abort}, 5'b01000);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (pc_done || init_done || m_abort) seen = 1;
    end
    chk("mr_no_pulse", seen, 0);
    pc_req = 1; pc_wr = 1; pc_addr = 8'h55; pc_wdata = 8'h11;
    tick();
    chk("mr_gnt", pc_gnt, 1);
    pc_req = 0;
    tick();
    chk("mr_start", {m_start, m_addr}, {1'b1, 8'h55});
    m_done = 1;
    tick();
    m_done = 0;
    chk("mr_done", {pc_done, pc_err}, 2'b10);
    wait_idle("mr_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sccb_cmd_arbiter.md
Name:
sccb_cmd_arbiter

Overview:
Shares the single SCCB master between two command sources: the camera boot-configuration sequencer ("init") and the PC packet decoder ("pc"). The PC decoder produces write/read register commands from received 0xEEBB-type frames. The block arbitrates requests, launches one SCCB transaction at a time, and guards against a hung master with a timeout. It enforces the SCCB bus-free gap between transactions and returns completion status and read data to the owning requester. It sits in the rxclk domain, between pcpacket's command decode and the SCCB bit engine.

Parameters:
DEV_ID, 8'h42, SCCB device write address driven on m_id (bit0 forced 1 by master for reads)
GAP_CYCLES, 125, idle rxclk cycles between transactions (10 us at 12.5 MHz); must be >= 1
TIMEOUT_CYCLES, 16'd50000, max rxclk cycles from m_start to m_done before abort

Ports:
rxclk  in  1  system clock, 12.5 MHz
rxreset  in  1  synchronous reset, active-low (0 = reset)
init_req  in  1  init command request; held until init_gnt
init_wr  in  1  1 = write, 0 = read
init_addr  in  8  register address
init_wdata  in  8  write data
init_gnt  out  1  one-cycle pulse: init command accepted
init_done  out  1  one-cycle pulse: init transaction finished
init_err  out  1  valid with init_done: NACK or timeout
pc_req  in  1  pc command request; held until pc_gnt
pc_wr  in  1  1 = write (packet byte 0xFF), 0 = read (0x00)
pc_addr  in  8  register address
pc_wdata  in  8  write data
pc_gnt  out  1  one-cycle pulse: pc command accepted
pc_done  out  1  one-cycle pulse: pc transaction finished
pc_err  out  1  valid with pc_done
pc_rdata  out  8  read data, valid from pc_done until the next pc_done
m_start  out  1  one-cycle launch pulse to SCCB master
m_abort  out  1  one-cycle pulse: master must release bus, return idle
m_wr  out  1  latched direction
m_id  out  8  DEV_ID
m_addr  out  8  latched address
m_wdata  out  8  latched write data
m_done  in  1  one-cycle pulse from master: transaction complete
m_nack  in  1  valid with m_done: slave did not acknowledge
m_rdata  in  8  valid with m_done on reads
busy  out  1  high in every state except IDLE
owner  out  1  0 = init, 1 = pc; owner of current/last transaction

Behaviour:
- Reset (rxreset=0 at a rising edge): state IDLE; all pulses 0; init_err=pc_err=0; pc_rdata=0; m_wr=0; m_addr=m_wdata=0; busy=0; owner=1, so init wins the first tie; counters cleared. Reset mid-transaction: no done pulse is issued and no m_abort is issued. The master is reset from the same rxreset.
- FSM states and transitions:
  - IDLE: at an edge with at least one req high, select a winner and latch its wr/addr/wdata. Assert that requester's gnt for 1 cycle, set owner, go to LAUNCH. With no req, stay in IDLE.
  - LAUNCH: m_start=1 for exactly 1 cycle; clear timeout counter; go to WAIT.
  - WAIT: on m_done, pulse the owner's done, set err=m_nack, and go to GAP. On a read, latch pc_rdata=m_rdata when owner=pc; init read data is discarded. If the counter reaches TIMEOUT_CYCLES-1 with no m_done: pulse m_abort and owner done with err=1, leave pc_rdata unchanged, go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Arbitration: if only one req is high, that requester wins. If both are high, the requester that is not the current owner wins (round-robin).
- A req seen while not in IDLE is ignored and does not queue. A req dropped before gnt withdraws the request. A req still high after gnt is treated as a new request at the next IDLE.
- m_done arriving in IDLE, LAUNCH or GAP is ignored. If m_done arrives in the same cycle the timeout fires, m_done wins: normal completion, no abort.
- Latency: gnt is 1 cycle after req is first sampled in IDLE; m_start is 1 cycle after gnt; done is 1 cycle after m_done. Minimum spacing from done to the next gnt is GAP_CYCLES+1 cycles.
- err is held until that requester's next done.

Test Plan:
- Write path: pc_req with wr=1, addr=0x13, wdata=0xCC -> pc_gnt next cycle, then m_start with m_addr=0x13, m_wdata=0xCC, m_wr=1; master m_done, m_nack=0 -> pc_done, pc_err=0.
- Read path: pc read of addr 0x13, master returns m_rdata=0x8F -> pc_done with pc_rdata=0x8F, held through a subsequent init transaction.
- Contention: init_req and pc_req both held continuously from reset -> grants alternate init, pc, init, pc, with each gnt at least GAP_CYCLES+1 cycles after the prior done.
- Timeout: master never pulses m_done -> m_abort and pc_done with pc_err=1 exactly TIMEOUT_CYCLES cycles after m_start; pc_rdata unchanged.
- NACK and boundary: m_nack=1 -> init_err=1. An m_done coincident with the timeout edge gives no m_abort and err=m_nack. A req asserted during GAP is granted only after GAP ends.
- Reset mid-WAIT: rxreset=0 for 1 cycle -> busy=0, no done pulses, owner=1; a following pc_req proceeds normally.
